mem_stage_unit: RTL and testbench



---
 rtl/mem_stage_unit.sv | 130 +++++++++++++
 tb/tb_mem_stage_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: executes loads/stores against a word-addressed data memory
// with a fixed multi-cycle latency and drives the registered MEM/WB outputs.
module mem_stage_unit #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        MemToReg,
  input  logic [31:0] ALUresult,
  input  logic [31:0] RtData,
  input  logic [4:0]  RdAddr,
  output logic        stall,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out,
  output logic [4:0]  RdAddr_out,
  output logic        misalign_out
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] counter;
  logic          accept, complete;
  logic          memop, aligned;

  logic          cap_read, cap_write, cap_regwrite, cap_memtoreg;
  logic [31:0]   cap_addr, cap_data;
  logic [4:0]    cap_rd;
  logic [AW-1:0] cap_index;

  logic [31:0]   mem [MEM_WORDS];

  assign memop     = MemRead | MemWrite;
  assign aligned   = (ALUresult[1:0] == 2'b00);
  assign cap_index = cap_addr[AW+1:2];

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (memop && aligned) begin
          stall      = 1'b1;
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (counter != '0) begin
          stall = 1'b1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The access always uses the request captured on entry to WAIT, never the live inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter       <= '0;
      cap_read      <= 1'b0;
      cap_write     <= 1'b0;
      cap_regwrite  <= 1'b0;
      cap_memtoreg  <= 1'b0;
      cap_addr      <= '0;
      cap_data      <= '0;
      cap_rd        <= '0;
      RegWrite_out  <= 1'b0;
      MemToReg_out  <= 1'b0;
      ReadData_out  <= '0;
      ALUresult_out <= '0;
      RdAddr_out    <= '0;
      misalign_out  <= 1'b0;
    end else if (accept) begin
      cap_read     <= MemRead;
      cap_write    <= MemWrite;
      cap_regwrite <= RegWrite;
      cap_memtoreg <= MemToReg;
      cap_addr     <= ALUresult;
      cap_data     <= RtData;
      cap_rd       <= RdAddr;
      counter      <= CW'(LATENCY - 1);
      RegWrite_out <= 1'b0;
      misalign_out <= 1'b0;
    end else if (state == WAIT) begin
      if (counter != '0) begin
        counter <= counter - 1'b1;
      end else begin
        RegWrite_out  <= cap_regwrite;
        MemToReg_out  <= cap_memtoreg;
        ALUresult_out <= cap_addr;
        RdAddr_out    <= cap_rd;
        misalign_out  <= 1'b0;
        ReadData_out  <= (cap_read && !cap_write) ? mem[cap_index] : '0;
      end
    end else begin
      // Any memop reaching here is unaligned: flag it and suppress write-back.
      RegWrite_out  <= RegWrite & ~memop;
      MemToReg_out  <= MemToReg;
      ALUresult_out <= ALUresult;
      RdAddr_out    <= RdAddr;
      ReadData_out  <= '0;
      misalign_out  <= memop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && complete && cap_write) mem[cap_index] <= cap_data;
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed self-checking bench for mem_stage_unit; three instances cover
// LATENCY = 2, 4 and 1, with the unused ones held in reset.
module tb_mem_stage_unit;

  logic        clk;
  logic        rst_a, rst_b, rst_c;
  logic        reg_write, mem_write, mem_read, mem_to_reg;
  logic [31:0] alu_result, rt_data;
  logic [4:0]  rd_addr;

  logic        stall_a, rw_a, m2r_a, mis_a;
  logic [31:0] rdata_a, alu_a;
  logic [4:0]  rd_a;
  logic        stall_b, rw_b, m2r_b, mis_b;
  logic [31:0] rdata_b, alu_b;
  logic [4:0]  rd_b;
  logic        stall_c, rw_c, m2r_c, mis_c;
  logic [31:0] rdata_c, alu_c;
  logic [4:0]  rd_c;

  logic        obs_stall, obs_rw, obs_m2r, obs_mis;
  logic [31:0] obs_rdata, obs_alu;
  logic [4:0]  obs_rd;
  int          sel;
  int          n_pass, n_total;
  int          falls_c;
  logic        prev_stall_c;

  mem_stage_unit #(.MEM_WORDS(256), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst_a), .RegWrite(reg_write), .MemWrite(mem_write), .MemRead(mem_read),
    .MemToReg(mem_to_reg), .ALUresult(alu_result), .RtData(rt_data), .RdAddr(rd_addr),
    .stall(stall_a), .RegWrite_out(rw_a), .MemToReg_out(m2r_a), .ReadData_out(rdata_a),
    .ALUresult_out(alu_a), .RdAddr_out(rd_a), .misalign_out(mis_a));

  mem_stage_unit #(.MEM_WORDS(256), .LATENCY(4)) dut_b (
    .clk(clk), .rst(rst_b), .RegWrite(reg_write), .MemWrite(mem_write), .MemRead(mem_read),
    .MemToReg(mem_to_reg), .ALUresult(alu_result), .RtData(rt_data), .RdAddr(rd_addr),
    .stall(stall_b), .RegWrite_out(rw_b), .MemToReg_out(m2r_b), .ReadData_out(rdata_b),
    .ALUresult_out(alu_b), .RdAddr_out(rd_b), .misalign_out(mis_b));

  mem_stage_unit #(.MEM_WORDS(256), .LATENCY(1)) dut_c (
    .clk(clk), .rst(rst_c), .RegWrite(reg_write), .MemWrite(mem_write), .MemRead(mem_read),
    .MemToReg(mem_to_reg), .ALUresult(alu_result), .RtData(rt_data), .RdAddr(rd_addr),
    .stall(stall_c), .RegWrite_out(rw_c), .MemToReg_out(m2r_c), .ReadData_out(rdata_c),
    .ALUresult_out(alu_c), .RdAddr_out(rd_c), .misalign_out(mis_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_stall = stall_a; obs_rw = rw_a; obs_m2r = m2r_a; obs_mis = mis_a;
    obs_rdata = rdata_a; obs_alu = alu_a; obs_rd = rd_a;
    if (sel == 1) begin
      obs_stall = stall_b; obs_rw = rw_b; obs_m2r = m2r_b; obs_mis = mis_b;
      obs_rdata = rdata_b; obs_alu = alu_b; obs_rd = rd_b;
    end else if (sel == 2) begin
      obs_stall = stall_c; obs_rw = rw_c; obs_m2r = m2r_c; obs_mis = mis_c;
      obs_rdata = rdata_c; obs_alu = alu_c; obs_rd = rd_c;
    end
  end

  // Each falling edge of the LATENCY=1 stall marks one completed access.
  initial falls_c = 0;
  initial prev_stall_c = 1'b0;
  always @(negedge clk) begin
    if (!rst_c && prev_stall_c && !stall_c) falls_c <= falls_c + 1;
    prev_stall_c <= stall_c;
  end

  task automatic set_in(input logic rw, input logic mr, input logic mw, input logic m2r,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
    alu_result = a; rt_data = d; rd_addr = rd;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic select_dut(input int k);
    sel   = k;
    rst_a = (k != 0);
    rst_b = (k != 1);
    rst_c = (k != 2);
  endtask

  // Entered at posedge+1 with a memop on the inputs; returns at posedge+1 after
  // the completion edge with the inputs already idled.
  task automatic run_op(input string name, output int cycles);
    logic s;
    bit   done;
    cycles = 0;
    done   = 0;
    for (int i = 0; i < 20; i++) begin
      #8;
      s = obs_stall;
      @(posedge clk); #1;
      if (s) cycles++;
      else begin done = 1; break; end
    end
    idle_in();
    n_total++;
    if (!done) $display("[TB] FAIL %s_timeout: got no completion expected completion within 20 cycles", name);
    else n_pass++;
  endtask

  task automatic test_reset();
    select_dut(0);
    rst_a = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if ({obs_rw, obs_m2r, obs_mis} !== 3'b000) $display("[TB] FAIL reset_ctrl: got %b expected 000", {obs_rw, obs_m2r, obs_mis}); else n_pass++;
    n_total++; if ({obs_rdata, obs_alu, obs_rd} !== 69'h0) $display("[TB] FAIL reset_data: got %h expected 0", {obs_rdata, obs_alu, obs_rd}); else n_pass++;
    rst_a = 1'b0;
    #8;
    n_total++; if (obs_stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", obs_stall); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_pass_through();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 5'd7);
    #8;
    n_total++; if (obs_stall !== 1'b0) $display("[TB] FAIL pt_stall: got %b expected 0", obs_stall); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (obs_rw !== 1'b1) $display("[TB] FAIL pt_regwrite: got %b expected 1", obs_rw); else n_pass++;
    n_total++; if (obs_alu !== 32'h0000_1234) $display("[TB] FAIL pt_alu: got %h expected 00001234", obs_alu); else n_pass++;
    n_total++; if (obs_rd !== 5'd7) $display("[TB] FAIL pt_rd: got %0d expected 7", obs_rd); else n_pass++;
    n_total++; if (obs_rdata !== 32'h0) $display("[TB] FAIL pt_rdata: got %h expected 0", obs_rdata); else n_pass++;
    idle_in();
  endtask

  task automatic test_store_load();
    int cyc;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0);
    run_op("sw", cyc);
    n_total++; if (cyc != 2) $display("[TB] FAIL sw_stall_cycles: got %0d expected 2", cyc); else n_pass++;
    n_total++; if (obs_rdata !== 32'h0) $display("[TB] FAIL sw_rdata: got %h expected 0", obs_rdata); else n_pass++;
    n_total++; if (obs_alu !== 32'h10) $display("[TB] FAIL sw_alu: got %h expected 10", obs_alu); else n_pass++;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd5);
    run_op("lw", cyc);
    n_total++; if (cyc != 2) $display("[TB] FAIL lw_stall_cycles: got %0d expected 2", cyc); else n_pass++;
    n_total++; if (obs_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL lw_rdata: got %h expected deadbeef", obs_rdata); else n_pass++;
    n_total++; if (obs_rd !== 5'd5) $display("[TB] FAIL lw_rd: got %0d expected 5", obs_rd); else n_pass++;
    n_total++; if ({obs_rw, obs_m2r} !== 2'b11) $display("[TB] FAIL lw_ctrl: got %b expected 11", {obs_rw, obs_m2r}); else n_pass++;
  endtask

  task automatic test_misaligned();
    int cyc;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd9);
    #8;
    n_total++; if (obs_stall !== 1'b0) $display("[TB] FAIL mis_stall: got %b expected 0", obs_stall); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({obs_mis, obs_rw} !== 2'b10) $display("[TB] FAIL mis_flags: got %b expected 10", {obs_mis, obs_rw}); else n_pass++;
    n_total++; if (obs_alu !== 32'h13 || obs_rd !== 5'd9) $display("[TB] FAIL mis_pass: got %h/%0d expected 13/9", obs_alu, obs_rd); else n_pass++;
    idle_in();
    @(posedge clk); #1;
    n_total++; if (obs_mis !== 1'b0) $display("[TB] FAIL mis_clear: got %b expected 0", obs_mis); else n_pass++;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 32'h0BAD_0BAD, 5'd0);
    @(posedge clk); #1;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd6);
    run_op("mis_lw", cyc);
    n_total++; if (obs_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL mis_mem_unchanged: got %h expected deadbeef", obs_rdata); else n_pass++;
  endtask

  task automatic test_wrap();
    int cyc;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'hA5A5_A5A5, 5'd0);
    run_op("wrap_sw", cyc);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd3);
    run_op("wrap_lw", cyc);
    n_total++; if (obs_rdata !== 32'hA5A5_A5A5) $display("[TB] FAIL wrap_rdata: got %h expected a5a5a5a5", obs_rdata); else n_pass++;
    n_total++; if (obs_alu !== 32'h0) $display("[TB] FAIL wrap_alu: got %h expected 0", obs_alu); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    select_dut(1);
    idle_in();
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h2222_2222, 5'd0);
    run_op("l4_sw", cyc);
    n_total++; if (cyc != 4) $display("[TB] FAIL l4_stall_cycles: got %0d expected 4", cyc); else n_pass++;
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h1111_1111, 5'd12);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b1;
    idle_in();
    @(posedge clk); #1;
    n_total++; if ({obs_rw, obs_m2r, obs_mis, obs_rdata, obs_alu, obs_rd} !== 72'h0) $display("[TB] FAIL midrst_outputs: got %h expected 0", {obs_rw, obs_m2r, obs_mis, obs_rdata, obs_alu, obs_rd}); else n_pass++;
    rst_b = 1'b0;
    #8;
    n_total++; if (obs_stall !== 1'b0) $display("[TB] FAIL midrst_stall: got %b expected 0", obs_stall); else n_pass++;
    @(posedge clk); #1;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd2);
    run_op("midrst_lw", cyc);
    n_total++; if (obs_rdata !== 32'h2222_2222) $display("[TB] FAIL midrst_rdata: got %h expected 22222222", obs_rdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2, base;
    select_dut(2);
    idle_in();
    @(posedge clk); #1;
    base = falls_c;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h55, 5'd0);
    run_op("b2b_sw", cyc1);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 5'd4);
    run_op("b2b_lw", cyc2);
    n_total++; if (cyc1 != 1 || cyc2 != 1) $display("[TB] FAIL b2b_stall_cycles: got %0d,%0d expected 1,1", cyc1, cyc2); else n_pass++;
    n_total++; if (obs_rdata !== 32'h55) $display("[TB] FAIL b2b_rdata: got %h expected 55", obs_rdata); else n_pass++;
    n_total++; if (obs_rd !== 5'd4 || obs_alu !== 32'h8) $display("[TB] FAIL b2b_dest: got %0d/%h expected 4/8", obs_rd, obs_alu); else n_pass++;
    #8;
    n_total++; if (obs_stall !== 1'b0) $display("[TB] FAIL b2b_idle_stall: got %b expected 0", obs_stall); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (falls_c - base != 2) $display("[TB] FAIL b2b_completions: got %0d expected 2", falls_c - base); else n_pass++;
    n_total++; if (obs_rw !== 1'b0) $display("[TB] FAIL b2b_nop_regwrite: got %b expected 0", obs_rw); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    sel     = 0;
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    rst_c   = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_pass_through();
    test_store_load();
    test_misaligned();
    test_wrap();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
